// File: rtl/param_updown_counter.sv
// Up/down counter with programmable inclusive limits, clamped load,
// wrap or saturate at the limits, and registered event pulses.
module param_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             at_min,
  output logic             at_max,
  output logic             wrap_p,
  output logic             sat_p,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             hit_top, hit_bot;

  assign cfg_err = min_val > max_val;
  assign hit_top = count_q >= max_val;
  assign hit_bot = count_q <= min_val;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (cfg_err) begin
      count_d = count_q;
    end else if (load) begin
      if (load_val < min_val)
        count_d = min_val;
      else if (load_val > max_val)
        count_d = max_val;
      else
        count_d = load_val;
    end else if (en) begin
      // limit checks come first, so +1/-1 can never overflow
      if (up_dn) begin
        if (!hit_top) begin
          count_d = count_q + 1'b1;
        end else if (sat_mode) begin
          count_d = max_val;
          sat_d   = 1'b1;
        end else begin
          count_d = min_val;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!hit_bot) begin
          count_d = count_q - 1'b1;
        end else if (sat_mode) begin
          count_d = min_val;
          sat_d   = 1'b1;
        end else begin
          count_d = max_val;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_CNT;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count  = count_q;
  assign wrap_p = wrap_q;
  assign sat_p  = sat_q;
  assign at_min = count_q == min_val;
  assign at_max = count_q == max_val;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: driver pushes reference-model expectations,
// monitor pops and compares them on each falling edge.
module tb_param_updown_counter;

  localparam int W  = 4;
  localparam int RV = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic         sat_mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] min_val = '0;
  logic [W-1:0] max_val = '0;
  logic [W-1:0] count;
  logic         at_min, at_max, wrap_p, sat_p, cfg_err;

  param_updown_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
    .sat_mode(sat_mode), .load(load), .load_val(load_val),
    .min_val(min_val), .max_val(max_val), .count(count),
    .at_min(at_min), .at_max(at_max), .wrap_p(wrap_p),
    .sat_p(sat_p), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit wrp;
    bit sat;
    bit amin;
    bit amax;
    bit cerr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_cnt = 0;
  bit   m_ok = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // behavioural reference: integer arithmetic on the rule set
  task automatic step(bit r, bit e, bit u, bit s, bit l,
                      int lv, int mn, int mx);
    exp_t x;
    int   prev;
    reset = r; en = e; up_dn = u; sat_mode = s; load = l;
    load_val = W'(lv); min_val = W'(mn); max_val = W'(mx);
    prev = m_cnt;
    x.wrp = 0;
    x.sat = 0;
    if (r) begin
      m_cnt = RV;
    end else if (mn > mx) begin
      m_cnt = m_cnt;
    end else if (l) begin
      m_cnt = (lv < mn) ? mn : (lv > mx) ? mx : lv;
    end else if (e) begin
      if (u ? (m_cnt < mx) : (m_cnt > mn))
        m_cnt = u ? m_cnt + 1 : m_cnt - 1;
      else if (s) begin
        m_cnt = u ? mx : mn;
        x.sat = 1;
      end else begin
        m_cnt = u ? mn : mx;
        x.wrp = 1;
      end
    end
    x.cnt  = m_cnt;
    x.amin = (m_cnt == mn);
    x.amax = (m_cnt == mx);
    x.cerr = (mn > mx);
    q.push_back(x);
    // inputs changed mid-cycle must not move count before the edge
    #2;
    if (m_ok) chk("hold_between_edges", int'(count), prev);
    if (r) m_ok = 1;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count", int'(count), x.cnt);
        chk("wrap_p", int'(wrap_p), int'(x.wrp));
        chk("sat_p", int'(sat_p), int'(x.sat));
        chk("at_min", int'(at_min), int'(x.amin));
        chk("at_max", int'(at_max), int'(x.amax));
        chk("cfg_err", int'(cfg_err), int'(x.cerr));
      end
    end
  end

  initial begin : driver
    int mn, mx, a, b;
    @(negedge clk);
    #1;
    // full-range wrap up from reset
    step(1, 0, 1, 0, 0, 0, 0, 15);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 0, 0, 0, 0, 15);
    // wrap down in 3..9 from 5
    step(0, 0, 0, 0, 1, 5, 3, 9);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 3, 9);
    // saturate up from 8
    step(0, 0, 1, 1, 1, 8, 3, 9);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 3, 9);
    // clamped loads, load beats en
    step(0, 0, 0, 0, 1, 12, 3, 9);
    step(0, 0, 0, 0, 1, 1, 3, 9);
    step(0, 1, 0, 0, 1, 5, 3, 9);
    // bad config freezes everything
    step(0, 1, 1, 0, 1, 2, 10, 4);
    step(0, 1, 0, 1, 1, 0, 10, 4);
    step(0, 1, 1, 0, 0, 0, 0, 4);
    step(0, 1, 1, 0, 0, 0, 0, 4);
    // min == max
    step(0, 1, 1, 0, 0, 0, 6, 6);
    step(0, 1, 0, 0, 0, 0, 6, 6);
    step(0, 1, 1, 1, 0, 0, 6, 6);
    // reset mid-count wins over load and en
    step(0, 0, 1, 0, 1, 7, 0, 15);
    step(1, 1, 1, 0, 1, 12, 0, 15);
    // randomized traffic
    mn = 0;
    mx = 15;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        mn = (a < b) ? a : b;
        mx = (a < b) ? b : a;
        if ($urandom_range(0, 9) == 0) begin
          mn = mx + 1;
          if (mn > 15) mn = 15;
        end
      end
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 8,
           1'($urandom),
           1'($urandom),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 15), mn, mx);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
